// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, load-use interlock, flush, handshakes.
// Build macro FORWARDING_EN: defined -> EX/MEM and MEM/WB bypass; undefined -> stall until writers retire.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rs1_used_i,
  input  logic                      rs2_used_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic                      alu_src_i,
  input  logic [3:0]                alu_ctrl_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      flush_i,
  input  logic                      exmem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0]     exmem_data_i,
  input  logic                      memwb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0]     memwb_data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_WIDTH-1:0]     op1_o,
  output logic [DATA_WIDTH-1:0]     op2_o,
  output logic [3:0]                alu_ctrl_o,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [CNT_WIDTH-1:0]      stall_count_o
);

  logic                      r_valid;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_addr, r_rs2_addr, r_rd;
  logic [DATA_WIDTH-1:0]     r_rs1_data, r_rs2_data, r_imm;
  logic                      r_alu_src, r_reg_write, r_mem_read, r_mem_write;
  logic [3:0]                r_alu_ctrl;
  logic [CNT_WIDTH-1:0]      r_stall_cnt;

  logic [DATA_WIDTH-1:0]     w_fwd_rs1, w_fwd_rs2;
  logic                      w_hazard, w_adv, w_fire;

`ifdef FORWARDING_EN
  // EX/MEM is the younger producer, so it overrides MEM/WB; x0 never forwards.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (r_rs1_addr != '0 && memwb_reg_write_i && memwb_rd_i == r_rs1_addr) w_fwd_rs1 = memwb_data_i;
    if (r_rs1_addr != '0 && exmem_reg_write_i && exmem_rd_i == r_rs1_addr) w_fwd_rs1 = exmem_data_i;
    w_fwd_rs2 = r_rs2_data;
    if (r_rs2_addr != '0 && memwb_reg_write_i && memwb_rd_i == r_rs2_addr) w_fwd_rs2 = memwb_data_i;
    if (r_rs2_addr != '0 && exmem_reg_write_i && exmem_rd_i == r_rs2_addr) w_fwd_rs2 = exmem_data_i;
  end

  assign w_hazard = r_valid & r_mem_read & (r_rd != '0) & valid_i &
                    ((rs1_used_i & (rs1_addr_i == r_rd)) | (rs2_used_i & (rs2_addr_i == r_rd)));
`else
  logic w_hit1, w_hit2, w_unused;

  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;

  // Without bypass, any in-flight writer of a used source blocks issue until it has retired.
  assign w_hit1 = rs1_used_i & (rs1_addr_i != '0) &
                  ((r_valid & r_reg_write & (r_rd == rs1_addr_i)) |
                   (exmem_reg_write_i & (exmem_rd_i == rs1_addr_i)) |
                   (memwb_reg_write_i & (memwb_rd_i == rs1_addr_i)));
  assign w_hit2 = rs2_used_i & (rs2_addr_i != '0) &
                  ((r_valid & r_reg_write & (r_rd == rs2_addr_i)) |
                   (exmem_reg_write_i & (exmem_rd_i == rs2_addr_i)) |
                   (memwb_reg_write_i & (memwb_rd_i == rs2_addr_i)));
  assign w_hazard = valid_i & (w_hit1 | w_hit2);
  assign w_unused = ^{exmem_data_i, memwb_data_i, r_rs1_addr, r_rs2_addr, r_mem_read};
`endif

  assign w_adv   = ready_i | ~r_valid;
  assign ready_o = w_adv & ~w_hazard & ~flush_i;
  assign w_fire  = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_fire;
      if (w_fire) begin
        r_rs1_addr  <= rs1_addr_i;
        r_rs2_addr  <= rs2_addr_i;
        r_rd        <= rd_addr_i;
        r_rs1_data  <= rs1_data_i;
        r_rs2_data  <= rs2_data_i;
        r_imm       <= imm_i;
        r_alu_src   <= alu_src_i;
        r_alu_ctrl  <= alu_ctrl_i;
        r_reg_write <= reg_write_i;
        r_mem_read  <= mem_read_i;
        r_mem_write <= mem_write_i;
      end
    end else begin
      // Producers may retire while we are held; capture their values before they vanish.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_stall_cnt <= '0;
    else if (valid_i && !ready_o && !flush_i && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
  end

  assign valid_o       = r_valid;
  assign op1_o         = w_fwd_rs1;
  assign op2_o         = r_alu_src ? r_imm : w_fwd_rs2;
  assign store_data_o  = w_fwd_rs2;
  assign alu_ctrl_o    = r_alu_ctrl;
  assign rd_addr_o     = r_rd;
  assign reg_write_o   = r_valid & r_reg_write;
  assign mem_read_o    = r_valid & r_mem_read;
  assign mem_write_o   = r_valid & r_mem_write;
  assign stall_count_o = r_stall_cnt;

endmodule
